uart_rx: RTL
============

# uart_rx

Receives 8N1 asynchronous serial frames (1 start, 8 data LSB-first, 1 stop, no parity) on `rx` and presents each byte to the core on a valid/ready handshake. It is the receive-side counterpart of the UART transmitter, at the same default rate of 9600 baud from a 50 MHz `clk`. It sits between the board RX pin and the CPU's memory-mapped UART register. It uses 16x oversampling, mid-bit sampling, false-start rejection, and framing/overrun detection.

## Interface
- `clks_per_bit`, default 5200: `clk` cycles per bit. Must be a multiple of 16 and at least 32.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `data_out`  out  8  last received byte; stable while `data_valid` is high.
- `data_valid`  out  1  byte available; held until accepted.
- `data_ready`  in  1  consumer accepts the byte on any edge where `data_valid` and `data_ready` are both high.
- `framing_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a frame completes while `data_valid` is still high.

## Operation
- **Input synchronizer:** `rx` passes through 2 flops, both reset to 1. The falling-edge detector compares the 2nd flop with a 3rd flop.
- **Prescaler:** counts 0 to `clks_per_bit/16 - 1` and emits a one-cycle tick at terminal count.
- **Bit-phase counter:** 4 bits, 0..15, advances on each tick.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:**
  - On a falling edge of synced `rx`, clear the prescaler and phase counter, then go to START.
  - Ticks are ignored in IDLE.
- **START:**
  - At the sample point, a 0 means go to DATA with bit index 0.
  - A 1 means false start: go to IDLE, with no outputs.
- **DATA:**
  - At each sample point, shift the sample into bit[index].
  - After index 7, go to STOP.
- **STOP, at the sample point:**
  - Sample 1 and `data_valid`=0: load `data_out`, set `data_valid`, go to IDLE.
  - Sample 1 and `data_valid`=1: drop the byte, keep the old `data_out`, pulse `overrun`, go to IDLE.
  - Sample 0: pulse `framing_err`, drop the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** return to IDLE once synced `rx` has been 1 for one full bit time (16 ticks). This handles break conditions.
- **Handshake:** `data_valid` clears on the edge after an accepted transfer. If that edge also loads a new byte, the load wins: `data_valid` stays 1 and `data_out` takes the new value, with no overrun.
- **Reset:** on any edge with `rst`=0:
  - All state returns to IDLE.
  - `data_out`=0x00; `data_valid`, `framing_err` and `overrun` are 0.
  - The synchronizer flops are set to 1.
  - Any frame in progress is discarded. A reset mid-frame must not produce a spurious byte when it releases mid-frame; the remaining line activity counts as a new start only on a fresh falling edge.

## Timing
- Tick period is `clks_per_bit/16` clk cycles.
- Synchronizer plus edge detect adds 3 cycles of latency from the pin.
- The sample point is tick phase 8 of each bit, measured from the detected start edge.
- `data_valid` rises 1 cycle after the stop-bit sample point. That is about 9.5 bit times after the start edge, which leaves half a stop bit of slack for back-to-back frames and transmitter clock skew of up to ±2%.
- `framing_err` and `overrun` are asserted for exactly 1 clk cycle.

## Configuration
- **Macro `UART_RX_MAJORITY_EN`.**
- **Defined:** the bit value is the 2-of-3 majority of the samples at phases 7, 8 and 9. The decision is taken at phase 9, so all sample points and `data_valid` move 1 tick later.
- **Undefined:** a single sample at phase 8.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum `uart_rx_state_t`.
  - `UART_OVERSAMPLE` = 16.
  - `UART_DATA_BITS` = 8.
  - Sample-phase constants `UART_SAMPLE_PHASE` = 8 and `UART_MAJ_FIRST` = 7.
- **Sub-module `uart_baud_tick`:**
  - Parameterised prescaler with a synchronous clear input and a tick output.
  - Instantiated once here; reusable by a future transmitter revision.

## Test plan
All scenarios use `clks_per_bit`=32.
- **Basic byte:** frame 0xA5, `data_ready` held 1 → `data_out`=0xA5, `data_valid` high for 1 cycle.
- **Loopback:** `uart_tx` (same parameter) sends 0x00, 0xFF, 0x55 back-to-back → three bytes received in order, with no `framing_err`.
- **False start:** low pulse of 4 ticks → no `data_valid`, FSM back in IDLE; a following 0x3C is received correctly.
- **Framing:** frame 0x81 with stop bit driven 0 → `framing_err` pulse, no `data_valid`. After 16 idle ticks, 0x42 is received.
- **Overrun:** send 0x11 then 0x22 with `data_ready`=0 → `data_out`=0x11 retained, one `overrun` pulse. Then assert `data_ready` → `data_valid` drops.
- **Mid-bit glitch / reset:**
  - Two-clk low glitch at phase 8 of a 1 bit → bit flips without `UART_RX_MAJORITY_EN`; stays 1 with it.
  - Reset asserted mid-frame → all outputs return to reset values, and no byte appears on release.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t    receiver FSM state encoding
//   UART_OVERSAMPLE    ticks per bit (16x oversampling)
//   UART_DATA_BITS     data bits per frame (8N1)
//   UART_SAMPLE_PHASE  tick phase used as the mid-bit sample point
//   UART_MAJ_FIRST     first of the three phases used by majority voting
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE   = 16;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_SAMPLE_PHASE = 8;
    localparam int UART_MAJ_FIRST    = 7;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer.
//   data_out     received byte, stable while data_valid is high
//   data_valid   byte available, held until accepted
//   data_ready   consumer accepts when data_valid and data_ready are both high
//   framing_err  one-cycle pulse on a low stop bit
//   overrun      one-cycle pulse when a byte is dropped because data_valid is still set
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       framing_err;
    logic       overrun;

    modport master (
        output data_out,
        output data_valid,
        output framing_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  framing_err,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_baud_tick.sv
// uart_baud_tick: prescaler producing a one-cycle tick every divisor clk cycles.
//   clk    system clock
//   rst    synchronous, active-low reset
//   clear  restarts the count from 0 (no tick in the clearing cycle)
//   tick   high for one cycle when the count is at divisor-1
module uart_baud_tick #(
    parameter int divisor = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = (divisor > 1) ? $clog2(divisor) : 1;
    localparam logic [W-1:0] TERMINAL = W'(divisor - 1);

    logic [W-1:0] count_reg;

    assign tick = (count_reg == TERMINAL) && !clear;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear || count_reg == TERMINAL) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, mid-bit sampling,
// false-start rejection and framing/overrun detection.
//   clk   system clock
//   rst   synchronous, active-low reset
//   rx    asynchronous serial input, idle high
//   bus   uart_rx_if.master: data_out/data_valid/data_ready handshake,
//         framing_err and overrun pulses
// Optional macro UART_RX_MAJORITY_EN: when defined, each bit is the 2-of-3
// majority of the samples at phases 7, 8 and 9 (decision at phase 9);
// otherwise a single sample is taken at phase 8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clks_per_bit = 5200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_if.master    bus
);
    localparam int TICK_DIV = clks_per_bit / UART_OVERSAMPLE;

    // Synchronizer and edge detector
    logic sync1_reg, sync2_reg, sync3_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            sync3_reg <= 1'b1;
        end else begin
            sync1_reg <= rx;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    // The synchronizer reloads with 1s on reset, so releasing reset while the
    // pin is low would look like a falling edge. Edge detection stays disarmed
    // until the pin itself has been seen high after reset.
    logic rel_reg;
    logic armed_reg;
    logic fall;

    assign fall = armed_reg && sync3_reg && !sync2_reg;

    // Prescaler and bit-phase counter
    uart_rx_state_t state_reg;
    logic           tick;
    logic           clear;
    logic [3:0]     phase_reg;

    assign clear = (state_reg == IDLE) && fall;

    uart_baud_tick #(
        .divisor(TICK_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            phase_reg <= '0;
        end else if (tick) begin
            phase_reg <= phase_reg + 4'd1;
        end
    end

    // Bit decision
    logic sample_en;
    logic bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic s7_reg, s8_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s7_reg <= 1'b1;
            s8_reg <= 1'b1;
        end else if (tick) begin
            if (phase_reg == 4'(UART_MAJ_FIRST))     s7_reg <= sync2_reg;
            if (phase_reg == 4'(UART_MAJ_FIRST + 1)) s8_reg <= sync2_reg;
        end
    end

    assign sample_en = tick && (phase_reg == 4'(UART_MAJ_FIRST + 2));
    assign bit_val   = (s7_reg & s8_reg) | (s7_reg & sync2_reg) | (s8_reg & sync2_reg);
`else
    assign sample_en = tick && (phase_reg == 4'(UART_SAMPLE_PHASE));
    assign bit_val   = sync2_reg;
`endif

    // Receiver FSM with registered outputs
    logic [2:0] bit_idx_reg;
    logic [7:0] shift_reg;
    logic [3:0] idle_cnt_reg;
    logic [7:0] data_out_reg;
    logic       data_valid_reg;
    logic       framing_err_reg;
    logic       overrun_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            idle_cnt_reg    <= '0;
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            rel_reg         <= 1'b0;
            armed_reg       <= 1'b0;
        end else begin
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            rel_reg         <= 1'b1;
            // sync1 reflects the pin only from the second cycle after release
            armed_reg       <= armed_reg | (rel_reg & sync1_reg);

            if (data_valid_reg && bus.data_ready) begin
                data_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    if (sample_en) begin
                        if (!bit_val) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample_en) begin
                        shift_reg[bit_idx_reg] <= bit_val;
                        if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (sample_en) begin
                        if (bit_val) begin
                            // A byte accepted on this same edge frees the slot,
                            // so the new byte loads instead of overrunning.
                            if (!data_valid_reg || bus.data_ready) begin
                                data_out_reg   <= shift_reg;
                                data_valid_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                            state_reg <= IDLE;
                        end else begin
                            framing_err_reg <= 1'b1;
                            idle_cnt_reg    <= '0;
                            state_reg       <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // Line must stay high for 16 consecutive ticks (break recovery)
                    if (!sync2_reg) begin
                        idle_cnt_reg <= '0;
                    end else if (tick) begin
                        if (idle_cnt_reg == 4'(UART_OVERSAMPLE - 1)) begin
                            state_reg <= IDLE;
                        end else begin
                            idle_cnt_reg <= idle_cnt_reg + 4'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.data_out    = data_out_reg;
    assign bus.data_valid  = data_valid_reg;
    assign bus.framing_err = framing_err_reg;
    assign bus.overrun     = overrun_reg;
endmodule
